// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use / jump-register stall and branch flush control
module id_ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  id_opcode,
  input  logic [1:0]  id_PCSrc,
  input  logic [1:0]  id_RegDst,
  input  logic [1:0]  id_MemtoReg,
  input  logic        id_RegWrite,
  input  logic        id_MemRead,
  input  logic        id_MemWrite,
  input  logic        id_ALUSrc1,
  input  logic        id_ALUSrc2,
  input  logic        id_ExtOp,
  input  logic        id_LuOp,
  input  logic [3:0]  id_ALUOp,
  input  logic [2:0]  id_Branch_Type,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [4:0]  id_shamt,
  input  logic [5:0]  id_funct,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm_ext,
  input  logic [31:0] id_pc_plus4,
  input  logic        mem_MemRead,
  input  logic [4:0]  mem_dst,
  input  logic        ex_branch_taken,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic [1:0]  ex_PCSrc,
  output logic [1:0]  ex_RegDst,
  output logic [1:0]  ex_MemtoReg,
  output logic        ex_RegWrite,
  output logic        ex_MemRead,
  output logic        ex_MemWrite,
  output logic        ex_ALUSrc1,
  output logic        ex_ALUSrc2,
  output logic        ex_ExtOp,
  output logic        ex_LuOp,
  output logic [3:0]  ex_ALUOp,
  output logic [2:0]  ex_Branch_Type,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_rd,
  output logic [4:0]  ex_shamt,
  output logic [5:0]  ex_funct,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [31:0] ex_imm_ext,
  output logic [31:0] ex_pc_plus4,
  output logic [4:0]  ex_dst,
  output logic        ex_is_branch,
  output logic [31:0] stall_count
);
  logic       rt_used, load_use, jr_hazard, stall, bubble, is_branch;
  logic [4:0] dst;
  always_comb begin
    rt_used   = id_opcode inside {6'h00, 6'h04, 6'h05, 6'h2b};
    load_use  = ex_MemRead && ex_dst != 5'd0 &&
                (ex_dst == id_rs || (rt_used && ex_dst == id_rt));
    // jr/jalr read rs in ID, so a pending write in EX or a load in MEM must drain first
    jr_hazard = id_opcode == 6'h00 && id_PCSrc == 2'b11 &&
                ((ex_RegWrite && ex_dst != 5'd0 && ex_dst == id_rs) ||
                 (mem_MemRead && mem_dst != 5'd0 && mem_dst == id_rs));
    stall      = load_use || jr_hazard;
    pc_write   = ex_branch_taken || !stall;
    ifid_write = ex_branch_taken || !stall;
    ifid_flush = ex_branch_taken;
    bubble     = reset || ex_branch_taken || stall;
    dst        = id_RegDst == 2'b01 ? id_rd : id_RegDst == 2'b11 ? 5'd31 : id_rt;
    is_branch  = id_opcode inside {6'h01, 6'h04, 6'h05, 6'h06, 6'h07};
  end
  always_ff @(posedge clk) begin
    {ex_PCSrc, ex_RegDst, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite,
     ex_ALUSrc1, ex_ALUSrc2, ex_ExtOp, ex_LuOp, ex_ALUOp, ex_Branch_Type,
     ex_rs, ex_rt, ex_rd, ex_shamt, ex_funct, ex_rs_data, ex_rt_data,
     ex_imm_ext, ex_pc_plus4, ex_dst, ex_is_branch} <= bubble ? '0 :
    {id_PCSrc, id_RegDst, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite,
     id_ALUSrc1, id_ALUSrc2, id_ExtOp, id_LuOp, id_ALUOp, id_Branch_Type,
     id_rs, id_rt, id_rd, id_shamt, id_funct, id_rs_data, id_rt_data,
     id_imm_ext, id_pc_plus4, dst, is_branch};
    if (reset)
      stall_count <= '0;
    else if (stall && !ex_branch_taken && !(&stall_count))
      stall_count <= stall_count + 32'd1;
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of capture, bubbles, stall/flush priority and stall counting
module tb_id_ex_stage;
  logic        clk = 0, reset = 1;
  logic [5:0]  id_opcode = 0, id_funct = 0;
  logic [1:0]  id_PCSrc = 0, id_RegDst = 0, id_MemtoReg = 0;
  logic        id_RegWrite = 0, id_MemRead = 0, id_MemWrite = 0, id_ALUSrc1 = 0;
  logic        id_ALUSrc2 = 0, id_ExtOp = 0, id_LuOp = 0;
  logic [3:0]  id_ALUOp = 0;
  logic [2:0]  id_Branch_Type = 0;
  logic [4:0]  id_rs = 0, id_rt = 0, id_rd = 0, id_shamt = 0, mem_dst = 0;
  logic [31:0] id_rs_data = 0, id_rt_data = 0, id_imm_ext = 0, id_pc_plus4 = 0;
  logic        mem_MemRead = 0, ex_branch_taken = 0;
  logic        pc_write, ifid_write, ifid_flush;
  logic [1:0]  ex_PCSrc, ex_RegDst, ex_MemtoReg;
  logic        ex_RegWrite, ex_MemRead, ex_MemWrite, ex_ALUSrc1, ex_ALUSrc2, ex_ExtOp, ex_LuOp;
  logic [3:0]  ex_ALUOp;
  logic [2:0]  ex_Branch_Type;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt, ex_dst;
  logic [5:0]  ex_funct;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm_ext, ex_pc_plus4, stall_count;
  logic        ex_is_branch;
  int          n_checks = 0, n_fail = 0;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_PCSrc(id_PCSrc),
    .id_RegDst(id_RegDst), .id_MemtoReg(id_MemtoReg), .id_RegWrite(id_RegWrite),
    .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite), .id_ALUSrc1(id_ALUSrc1),
    .id_ALUSrc2(id_ALUSrc2), .id_ExtOp(id_ExtOp), .id_LuOp(id_LuOp), .id_ALUOp(id_ALUOp),
    .id_Branch_Type(id_Branch_Type), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_shamt(id_shamt), .id_funct(id_funct), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm_ext(id_imm_ext), .id_pc_plus4(id_pc_plus4),
    .mem_MemRead(mem_MemRead), .mem_dst(mem_dst), .ex_branch_taken(ex_branch_taken),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .ex_PCSrc(ex_PCSrc), .ex_RegDst(ex_RegDst), .ex_MemtoReg(ex_MemtoReg),
    .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
    .ex_ALUSrc1(ex_ALUSrc1), .ex_ALUSrc2(ex_ALUSrc2), .ex_ExtOp(ex_ExtOp), .ex_LuOp(ex_LuOp),
    .ex_ALUOp(ex_ALUOp), .ex_Branch_Type(ex_Branch_Type), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .ex_shamt(ex_shamt), .ex_funct(ex_funct), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm_ext(ex_imm_ext), .ex_pc_plus4(ex_pc_plus4),
    .ex_dst(ex_dst), .ex_is_branch(ex_is_branch), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [5:0] op, input logic [1:0] pcsrc, input logic [1:0] regdst,
                        input logic rw, input logic mr, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd);
    id_opcode = op; id_PCSrc = pcsrc; id_RegDst = regdst; id_RegWrite = rw;
    id_MemRead = mr; id_MemtoReg = {1'b0, mr}; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = 32'h1000 + {27'd0, rs};
    id_rt_data = 32'h2000 + {27'd0, rt};
    #1;
  endtask

  initial begin
    set_id(6'h08, 2'b00, 2'b00, 1, 1, 5'd4, 5'd5, 5'd6);
    id_pc_plus4 = 32'h0040_0004;
    tick();
    tick();
    check("rst_regwrite", {31'd0, ex_RegWrite}, 0);
    check("rst_dst", {27'd0, ex_dst}, 0);
    check("rst_rs_data", ex_rs_data, 0);
    check("rst_pc4", ex_pc_plus4, 0);
    check("rst_count", stall_count, 0);
    check("rst_hz", {29'd0, pc_write, ifid_write, ifid_flush}, 32'b110);
    reset = 0;
    // load-use: lw $8 then add rs=8
    set_id(6'h23, 2'b00, 2'b00, 1, 1, 5'd1, 5'd8, 5'd0);
    tick();
    check("lw_dst", {27'd0, ex_dst}, 8);
    check("lw_memread", {31'd0, ex_MemRead}, 1);
    check("lw_rs_data", ex_rs_data, 32'h1001);
    check("lw_pc4", ex_pc_plus4, 32'h0040_0004);
    set_id(6'h00, 2'b00, 2'b01, 1, 0, 5'd8, 5'd2, 5'd3);
    check("lu_stall", {30'd0, pc_write, ifid_write}, 0);
    tick();
    check("lu_bubble", {27'd0, ex_RegWrite, ex_dst}, 0);
    check("lu_count", stall_count, 1);
    check("lu_release", {31'd0, pc_write}, 1);
    tick();
    check("add_rs", {27'd0, ex_rs}, 8);
    check("add_dst", {27'd0, ex_dst}, 3);
    check("add_rw", {31'd0, ex_RegWrite}, 1);
    // rt_used rule
    set_id(6'h23, 2'b00, 2'b00, 1, 1, 5'd1, 5'd9, 5'd0);
    tick();
    set_id(6'h00, 2'b00, 2'b01, 1, 0, 5'd2, 5'd9, 5'd10);
    check("rt_used_stall", {31'd0, pc_write}, 0);
    set_id(6'h08, 2'b00, 2'b00, 1, 0, 5'd2, 5'd9, 5'd0);
    check("addi_nostall", {30'd0, pc_write, ifid_write}, 32'b11);
    tick();
    check("addi_dst", {27'd0, ex_dst}, 9);
    check("addi_count", stall_count, 1);
    // $0 never causes a hazard
    set_id(6'h23, 2'b00, 2'b00, 1, 1, 5'd1, 5'd0, 5'd0);
    tick();
    set_id(6'h00, 2'b00, 2'b01, 1, 0, 5'd0, 5'd0, 5'd7);
    check("zero_nostall", {31'd0, pc_write}, 1);
    tick();
    // jr behind an ALU write: one cycle
    set_id(6'h00, 2'b00, 2'b01, 1, 0, 5'd1, 5'd2, 5'd20);
    tick();
    set_id(6'h00, 2'b11, 2'b00, 0, 0, 5'd20, 5'd0, 5'd0);
    check("jr_alu_stall", {31'd0, pc_write}, 0);
    tick();
    check("jr_alu_release", {31'd0, pc_write}, 1);
    check("jr_alu_count", stall_count, 2);
    tick();
    // jr behind load: two cycles
    set_id(6'h23, 2'b00, 2'b00, 1, 1, 5'd1, 5'd31, 5'd0);
    tick();
    set_id(6'h00, 2'b11, 2'b00, 0, 0, 5'd31, 5'd0, 5'd0);
    check("jr_ld_stall1", {30'd0, pc_write, ifid_write}, 0);
    tick();
    mem_MemRead = 1; mem_dst = 5'd31; #1;
    check("jr_ld_stall2", {30'd0, pc_write, ifid_write}, 0);
    tick();
    mem_MemRead = 0; mem_dst = 5'd0; #1;
    check("jr_ld_release", {31'd0, pc_write}, 1);
    check("jr_ld_count", stall_count, 4);
    tick();
    check("jr_pcsrc", {30'd0, ex_PCSrc}, 3);
    // flush over stall
    set_id(6'h23, 2'b00, 2'b00, 1, 1, 5'd1, 5'd8, 5'd0);
    tick();
    set_id(6'h00, 2'b00, 2'b01, 1, 0, 5'd8, 5'd2, 5'd3);
    ex_branch_taken = 1; #1;
    check("flush_hz", {29'd0, pc_write, ifid_write, ifid_flush}, 32'b111);
    tick();
    ex_branch_taken = 0; #1;
    check("flush_bubble", {26'd0, ex_RegWrite, ex_MemRead, ex_dst}, 0);
    check("flush_rs_data", ex_rs_data, 0);
    check("flush_count", stall_count, 4);
    check("flush_after", {29'd0, pc_write, ifid_write, ifid_flush}, 32'b110);
    // jal and beq capture
    set_id(6'h03, 2'b01, 2'b11, 1, 0, 5'd0, 5'd0, 5'd0);
    tick();
    check("jal_dst", {27'd0, ex_dst}, 31);
    check("jal_rw_br", {30'd0, ex_RegWrite, ex_is_branch}, 32'b10);
    set_id(6'h04, 2'b00, 2'b00, 0, 0, 5'd3, 5'd4, 5'd0);
    tick();
    check("beq_branch", {31'd0, ex_is_branch}, 1);
    // reset during a stall
    set_id(6'h23, 2'b00, 2'b00, 1, 1, 5'd1, 5'd8, 5'd0);
    tick();
    set_id(6'h00, 2'b00, 2'b01, 1, 0, 5'd8, 5'd2, 5'd3);
    reset = 1;
    tick();
    reset = 0; #1;
    check("rst_mid_count", stall_count, 0);
    check("rst_mid_bubble", {31'd0, ex_MemRead}, 0);
    check("rst_mid_nostall", {31'd0, pc_write}, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated hazard detection for the five-stage MIPS core. It sits directly downstream of the instruction decoder and captures that decoder's control word together with register operands, immediate and PC+4 at each clock edge. It generates the stall and flush controls for the PC and the IF/ID register. On a load-use or jump-register hazard it inserts a bubble, and on a taken branch resolved in EX it squashes the instruction in ID.

## Interface
Parameters:
- none

Ports:
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- id_opcode  in  6  opcode of the instruction in ID
- id_PCSrc, id_RegDst, id_MemtoReg  in  2 each  decoder outputs
- id_RegWrite, id_MemRead, id_MemWrite, id_ALUSrc1, id_ALUSrc2, id_ExtOp, id_LuOp  in  1 each  decoder outputs
- id_ALUOp  in  4  decoder output
- id_Branch_Type  in  3  decoder output
- id_rs, id_rt, id_rd, id_shamt  in  5 each  instruction fields
- id_funct  in  6  instruction field
- id_rs_data, id_rt_data, id_imm_ext, id_pc_plus4  in  32 each  ID operands
- mem_MemRead  in  1  instruction in MEM is a load
- mem_dst  in  5  destination register of the instruction in MEM
- ex_branch_taken  in  1  branch in EX resolved taken, this cycle
- pc_write  out  1  0 = hold PC
- ifid_write  out  1  0 = hold IF/ID
- ifid_flush  out  1  1 = load IF/ID with a bubble
- ex_*  out  same widths as id_*  registered copies of every id_* input above except id_opcode
- ex_dst  out  5  registered destination: RegDst 00/10 → rt, 01 → rd, 11 → 31
- ex_is_branch  out  1  registered; 1 when the opcode was 01, 04, 05, 06 or 07
- stall_count  out  32  saturating count of hazard-stall cycles

## Operation
Hazard detection is combinational. It uses the current ID inputs, the registered ex_* state and the mem_* inputs.

- rt_used = opcode ∈ {00, 04, 05, 2b}.
- Load-use hazard:
  - ex_MemRead=1, ex_dst≠0, and either ex_dst==id_rs, or ex_dst==id_rt with rt_used.
- Jump-register hazard:
  - Applies when id_opcode==00 and id_PCSrc==11 (jr/jalr).
  - Case 1: ex_RegWrite=1, ex_dst≠0, ex_dst==id_rs.
  - Case 2: mem_MemRead=1, mem_dst≠0, mem_dst==id_rs.
- stall = load-use OR jump-register hazard.

Priority: flush over stall over normal.
- Flush (ex_branch_taken=1):
  - pc_write=1, ifid_write=1, ifid_flush=1.
  - The ID/EX register loads a bubble.
  - stall is ignored and stall_count is unchanged.
- Stall (flush=0):
  - pc_write=0, ifid_write=0, ifid_flush=0.
  - The ID/EX register loads a bubble.
  - stall_count increments by 1 and saturates at 0xFFFFFFFF.
- Normal:
  - pc_write=1, ifid_write=1, ifid_flush=0.
  - The ID/EX register captures all id_* fields.
  - ex_dst and ex_is_branch are derived as defined in the Interface section.

Bubble contents:
- ex_RegWrite, ex_MemRead, ex_MemWrite and ex_is_branch are 0.
- ex_PCSrc=00.
- ex_dst=0.
- All other ex_* fields are 0.

## Timing
- Reset:
  - Every ex_* output and stall_count read 0 on the cycle after reset is sampled high. The register then holds a bubble.
  - Hazard outputs are combinational. During reset they evaluate against the bubble state, so with ex_branch_taken=0 they read pc_write=1, ifid_write=1, ifid_flush=0.
- Latency: one cycle from id_* to ex_*.
- Stall durations:
  - Load-use: exactly 1 cycle.
  - jr behind an ALU write: 1 cycle.
  - jr directly behind a load: 2 cycles. The first cycle is caused by EX, the second by MEM.
- Outputs pc_write, ifid_write and ifid_flush are valid in the same cycle as their inputs. They have no registered delay.
- Flush and stall in the same cycle: flush wins; stall_count does not increment.
- id_rs==0 or id_rt==0 never causes a hazard.
- Reset asserted mid-stall: the bubble is loaded, stall_count clears, and no residual stall remains after reset.

## Test plan
- Reset: hold reset 2 cycles with ex_branch_taken=0 → all ex_*=0, stall_count=0, pc_write=1, ifid_write=1, ifid_flush=0.
- Load-use stall:
  - Stimulus: lw $8 (opcode 23, RegDst 00, rt=8) captured, then ID holds add rs=8 (opcode 00).
  - Required response: pc_write=0 and ifid_write=0 for 1 cycle, ex_RegWrite=0 the next cycle, then the add is captured with ex_rs=8; stall_count=1.
- rt_used rule:
  - Stimulus: lw $9 in EX, then ID holds addi with rt=9 (opcode 08).
  - Required response: no stall (rt_used=0); pc_write stays 1.
- jr behind load:
  - Stimulus: lw $31 in EX, ID holds jr rs=31 (PCSrc 11).
  - Required response: 2 stall cycles (the second with mem_MemRead=1, mem_dst=31); stall_count=2.
- Flush over stall:
  - Stimulus: load-use condition active and ex_branch_taken=1 in the same cycle.
  - Required response: pc_write=1, ifid_flush=1, ex_* becomes a bubble next cycle, stall_count unchanged.
- jal capture:
  - Stimulus: opcode 03 with RegDst 11 and RegWrite 1.
  - Required response: ex_dst=31, ex_RegWrite=1, ex_is_branch=0.
